// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between an instruction cache (I)
// and a data cache (D). Round-robin arbitration; one outstanding transaction.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   i_req/i_we/i_addr/i_wdata I-cache line request, write flag, address, write line
//   i_rdata/i_ack             read line returned to I-cache, one-cycle completion
//   d_*                       same set for the D-cache
//   mem_req/mem_we/mem_addr/mem_wdata  memory transaction toward main memory
//   mem_rdata/mem_ready       memory read line and one-cycle completion pulse
//   grant_owner               owner of the current transaction, 0 = I, 1 = D
module mem_port_arbiter #(
   parameter int unsigned MEM_ADDR_WIDTH = 4,
   parameter int unsigned LINE_BITS      = 128
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      i_req,
   input  logic                      i_we,
   input  logic [MEM_ADDR_WIDTH-1:0] i_addr,
   input  logic [LINE_BITS-1:0]      i_wdata,
   output logic [LINE_BITS-1:0]      i_rdata,
   output logic                      i_ack,
   input  logic                      d_req,
   input  logic                      d_we,
   input  logic [MEM_ADDR_WIDTH-1:0] d_addr,
   input  logic [LINE_BITS-1:0]      d_wdata,
   output logic [LINE_BITS-1:0]      d_rdata,
   output logic                      d_ack,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [LINE_BITS-1:0]      mem_wdata,
   input  logic [LINE_BITS-1:0]      mem_rdata,
   input  logic                      mem_ready,
   output logic                      grant_owner
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_e;

   state_e                      state_q, state_d;
   logic                        mem_req_q, mem_req_d;
   logic                        mem_we_q, mem_we_d;
   logic [MEM_ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [LINE_BITS-1:0]        mem_wdata_q, mem_wdata_d;
   logic                        owner_q, owner_d;
   logic                        last_q, last_d;
   logic                        i_ack_q, i_ack_d;
   logic                        d_ack_q, d_ack_d;
   logic [LINE_BITS-1:0]        i_rdata_q, i_rdata_d;
   logic [LINE_BITS-1:0]        d_rdata_q, d_rdata_d;
   logic                        win_c;

   // Winner: on a tie the side not granted last; otherwise whoever is asking.
   assign win_c = (i_req && d_req) ? ~last_q : d_req;

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      owner_d     = owner_q;
      last_d      = last_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;

      case (state_q)
         IDLE: begin
            // Latch the winner's fields so later requester changes cannot reach memory.
            if (i_req || d_req) begin
               state_d     = BUSY;
               owner_d     = win_c;
               last_d      = win_c;
               mem_req_d   = 1'b1;
               mem_we_d    = win_c ? d_we    : i_we;
               mem_addr_d  = win_c ? d_addr  : i_addr;
               mem_wdata_d = win_c ? d_wdata : i_wdata;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               state_d   = ACK;
               mem_req_d = 1'b0;
               if (!mem_we_q) begin
                  if (owner_q) d_rdata_d = mem_rdata;
                  else         i_rdata_d = mem_rdata;
               end
               if (owner_q) d_ack_d = 1'b1;
               else         i_ack_d = 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         owner_q     <= 1'b0;
         last_q      <= 1'b0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign grant_owner = owner_q;
   assign i_ack       = i_ack_q;
   assign d_ack       = d_ack_q;
   assign i_rdata     = i_rdata_q;
   assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, a latency-programmable memory responder, and directed scenarios with
// literal expectations.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 4;
   localparam int unsigned LB = 128;

   logic          clk = 1'b0;
   logic          rstn;
   logic          i_req, i_we, d_req, d_we;
   logic [AW-1:0] i_addr, d_addr;
   logic [LB-1:0] i_wdata, d_wdata;
   logic [LB-1:0] i_rdata, d_rdata;
   logic          i_ack, d_ack;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [LB-1:0] mem_wdata;
   logic [LB-1:0] mem_rdata;
   logic          mem_ready;
   logic          grant_owner;

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   // memory responder configuration
   bit            resp_en = 1'b1;
   int            lat = 2;
   logic [LB-1:0] resp_data = '0;
   int            resp_cnt = 0;

   mem_port_arbiter #(.MEM_ADDR_WIDTH(AW), .LINE_BITS(LB)) dut (
      .clk(clk), .rstn(rstn),
      .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .grant_owner(grant_owner)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      nvec++;
      nerr++;
      $display("FAIL %s: timed out waiting, expected event within budget", name);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic          m_active, m_ack_i, m_ack_d, m_owner, m_last, m_we;
   logic [AW-1:0] m_addr;
   logic [LB-1:0] m_wdata, m_rd_i, m_rd_d;

   function automatic logic pick(input logic ir, input logic dr, input logic last);
      return (ir && dr) ? !last : dr;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_active <= 1'b0; m_ack_i <= 1'b0; m_ack_d <= 1'b0;
         m_owner  <= 1'b0; m_last  <= 1'b0; m_we    <= 1'b0;
         m_addr   <= '0;   m_wdata <= '0;
         m_rd_i   <= '0;   m_rd_d  <= '0;
      end else if (m_ack_i || m_ack_d) begin
         // completion cycle: requests are not looked at
         m_ack_i <= 1'b0;
         m_ack_d <= 1'b0;
      end else if (m_active) begin
         if (mem_ready) begin
            m_active <= 1'b0;
            if (!m_we) begin
               if (m_owner) m_rd_d <= mem_rdata;
               else         m_rd_i <= mem_rdata;
            end
            if (m_owner) m_ack_d <= 1'b1;
            else         m_ack_i <= 1'b1;
         end
      end else if (i_req || d_req) begin
         m_active <= 1'b1;
         m_owner  <= pick(i_req, d_req, m_last);
         m_last   <= pick(i_req, d_req, m_last);
         m_we     <= pick(i_req, d_req, m_last) ? d_we    : i_we;
         m_addr   <= pick(i_req, d_req, m_last) ? d_addr  : i_addr;
         m_wdata  <= pick(i_req, d_req, m_last) ? d_wdata : i_wdata;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("mem_req",  LB'(mem_req), LB'(m_active));
         if (m_active) begin
            check("mem_we",      LB'(mem_we),      LB'(m_we));
            check("mem_addr",    LB'(mem_addr),    LB'(m_addr));
            check("mem_wdata",   mem_wdata,        m_wdata);
            check("grant_owner", LB'(grant_owner), LB'(m_owner));
         end
         check("i_ack",    LB'(i_ack), LB'(m_ack_i));
         check("d_ack",    LB'(d_ack), LB'(m_ack_d));
         check("ack_excl", LB'(i_ack & d_ack), LB'(0));
         check("i_rdata",  i_rdata, m_rd_i);
         check("d_rdata",  d_rdata, m_rd_d);
      end
   end

   // ---------------- memory responder ----------------
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         mem_ready = 1'b0;
         if (resp_en && mem_req) begin
            resp_cnt++;
            if (resp_cnt >= lat) begin
               mem_ready = 1'b1;
               mem_rdata = resp_data;
               resp_cnt  = 0;
            end
         end else begin
            resp_cnt = 0;
         end
      end
   end

   // Wait for either ack; cycle 1 is the cycle in which the call starts.
   task automatic wait_any_ack(input bit drop, output int who, output int cyc, output int nmreq);
      who = 2; cyc = 0; nmreq = 0;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (mem_req) nmreq++;
         if (i_ack || d_ack) begin
            who = d_ack ? 1 : 0;
            cyc = k;
            if (drop) begin
               if (d_ack) d_req = 1'b0;
               else       i_req = 1'b0;
            end
            return;
         end
      end
      fail_timeout("ack_wait");
   endtask

   task automatic wait_memreq(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if (mem_req) begin
            ok = 1'b1;
            return;
         end
      end
      fail_timeout("mem_req_wait");
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask

   // ---------------- directed scenarios ----------------
   logic [LB-1:0] pat_a, pat_5, pat_f, pat_c;
   bit            exp_seq [6];
   int            who, cyc, nmr;
   bit            ok;

   initial begin
      pat_a = {32{4'hA}};
      pat_5 = {32{4'h5}};
      pat_f = {32{4'hF}};
      pat_c = {32{4'hC}};
      exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      rstn = 1'b0;
      step();
      @(negedge clk);
      chk_en = 1'b1;
      // reset values
      check("rst_mem_req",   LB'(mem_req),     LB'(0));
      check("rst_mem_we",    LB'(mem_we),      LB'(0));
      check("rst_mem_addr",  LB'(mem_addr),    LB'(0));
      check("rst_mem_wdata", mem_wdata,        LB'(0));
      check("rst_grant",     LB'(grant_owner), LB'(0));
      check("rst_acks",      LB'({i_ack, d_ack}), LB'(0));
      check("rst_i_rdata",   i_rdata,          LB'(0));
      check("rst_d_rdata",   d_rdata,          LB'(0));
      step();
      rstn = 1'b1;

      // single read right after reset release, L=2
      lat = 2; resp_data = pat_a;
      i_addr = 4'h3; i_we = 1'b0; i_req = 1'b1;
      wait_any_ack(1'b1, who, cyc, nmr);
      check("rd_who",      LB'(who), LB'(0));
      check("rd_ack_cyc",  LB'(cyc), LB'(4));
      check("rd_mreq_cyc", LB'(nmr), LB'(2));
      @(negedge clk);
      check("rd_i_rdata",  i_rdata, pat_a);
      check("rd_ack_once", LB'(i_ack), LB'(0));

      // tie right after reset: D first, then I
      step();
      do_reset();
      lat = 1; resp_data = pat_f;
      i_addr = 4'h1; d_addr = 4'h2; i_req = 1'b1; d_req = 1'b1;
      wait_any_ack(1'b1, who, cyc, nmr);
      check("tie_first", LB'(who), LB'(1));
      wait_any_ack(1'b1, who, cyc, nmr);
      check("tie_second", LB'(who), LB'(0));

      // continuous contention: strict alternation starting with D
      step();
      lat = 3; resp_data = pat_5;
      i_req = 1'b1; d_req = 1'b1;
      for (int n = 0; n < 6; n++) begin
         wait_any_ack(1'b0, who, cyc, nmr);
         check($sformatf("rr_grant%0d", n), LB'(who), LB'(exp_seq[n]));
      end
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      check("rr_i_rdata", i_rdata, pat_5);
      check("rr_d_rdata", d_rdata, pat_5);

      // D write-back leaves d_rdata untouched
      step();
      lat = 2; resp_data = pat_f;
      d_we = 1'b1; d_addr = 4'h9; d_wdata = LB'(16'h1234); d_req = 1'b1;
      wait_memreq(ok);
      check("wb_mem_we",    LB'(mem_we),      LB'(1));
      check("wb_mem_addr",  LB'(mem_addr),    LB'(9));
      check("wb_mem_wdata", mem_wdata,        LB'(16'h1234));
      check("wb_owner",     LB'(grant_owner), LB'(1));
      wait_any_ack(1'b1, who, cyc, nmr);
      check("wb_who", LB'(who), LB'(1));
      d_we = 1'b0;
      @(negedge clk);
      check("wb_d_rdata", d_rdata, pat_5);

      // requester fields change and req drops during BUSY
      step();
      lat = 3; resp_data = pat_c;
      i_we = 1'b0; i_addr = 4'h2; i_req = 1'b1;
      wait_memreq(ok);
      i_addr = 4'h7; i_wdata = pat_f; i_we = 1'b1; i_req = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 32; k++) begin
         if (mem_req) check("fi_mem_addr", LB'(mem_addr), LB'(2));
         if (i_ack) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) fail_timeout("fi_ack");
      i_we = 1'b0;
      @(negedge clk);
      check("fi_i_rdata", i_rdata, pat_c);

      // reset during BUSY aborts without ack; stray mem_ready is ignored
      step();
      lat = 5;
      i_addr = 4'h4; i_req = 1'b1;
      wait_memreq(ok);
      #1 rstn = 1'b0;
      #1;
      check("ab_mem_req", LB'(mem_req), LB'(0));
      check("ab_acks",    LB'({i_ack, d_ack}), LB'(0));
      i_req = 1'b0;
      step();
      rstn = 1'b1;
      resp_en = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #3;
         if (k == 1) mem_ready = 1'b1;
         @(negedge clk);
         check($sformatf("ab_noack%0d", k), LB'({i_ack, d_ack, mem_req}), LB'(0));
      end
      check("ab_i_rdata", i_rdata, LB'(0));

      step();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_ADDR_WIDTH, default 4, meaning the line-address width toward main memory.
REQ-002 The block SHALL have parameter LINE_BITS, default 128, meaning the cache-line width in bits.
REQ-003 The block SHALL use reset rstn, asynchronous, active-low, and clock clk.
REQ-004 The block SHALL provide the following ports, listed as name, direction, width and meaning:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- i_req  in  1  instruction-cache line request.
- i_we  in  1  instruction-cache write-back, 1 = write.
- i_addr  in  MEM_ADDR_WIDTH  instruction-cache line address.
- i_wdata  in  LINE_BITS  instruction-cache write line.
- i_rdata  out  LINE_BITS  read line returned to the instruction cache.
- i_ack  out  1  one-cycle completion pulse to the instruction cache.
- d_req, d_we, d_addr, d_wdata, d_rdata, d_ack  same directions, widths and meanings as the i_* ports, for the data cache.
- mem_req  out  1  memory transaction valid.
- mem_we  out  1  memory write.
- mem_addr  out  MEM_ADDR_WIDTH  memory line address.
- mem_wdata  out  LINE_BITS  memory write line.
- mem_rdata  in  LINE_BITS  memory read line.
- mem_ready  in  1  memory completion, one-cycle pulse.
- grant_owner  out  1  owner of the current transaction, 0 = I, 1 = D, valid while busy.

Function
REQ-005 The FSM SHALL have three states: IDLE, BUSY and ACK.
REQ-006 In IDLE with any request asserted, the block SHALL register the winner's we, addr and wdata, set grant_owner, and enter BUSY on the next edge.
REQ-007 The block SHALL arbitrate round-robin: on a tie, the requester not granted last wins, and the last-grant register updates at each grant.
REQ-008 A single pending requester SHALL win regardless of the last-grant register.
REQ-009 In BUSY, mem_req SHALL be 1, and mem_we, mem_addr and mem_wdata SHALL equal the registered values and stay stable until mem_ready.
REQ-010 In BUSY with mem_ready=1, the block SHALL register mem_rdata into the owner's rdata register when the transaction is a read, and enter ACK.
REQ-011 On a write, the owner's rdata register SHALL be left unchanged.
REQ-012 In ACK, the owner's ack SHALL be 1 for exactly one cycle, mem_req SHALL be 0, and the next state SHALL be IDLE.
REQ-013 From the first request seen in IDLE to the owner's ack, latency SHALL be (memory latency L + 2) cycles, where L counts cycles from mem_req to mem_ready.
REQ-014 Requesters hold req and their fields stable until ack and drop req in the ack cycle; a req still high in the cycle after ack SHALL be treated as a new request.
REQ-015 Requester fields that change during BUSY SHALL be ignored, because the registered copies drive memory.
REQ-016 If a requester deasserts req during BUSY, the transaction SHALL still complete and ack SHALL still pulse.
REQ-017 mem_ready SHALL be ignored in IDLE and ACK.
REQ-018 At most one of i_ack and d_ack SHALL be high in any cycle, and neither SHALL be high outside ACK.
REQ-019 i_rdata and d_rdata SHALL hold their last value until the next read completes for that requester.
REQ-020 The non-owner's requests SHALL wait, with no ack, until the owner's transaction finishes.
REQ-021 With both requesters continuously requesting, grants SHALL strictly alternate.

Reset
REQ-022 While rstn=0, asynchronously: state = IDLE; mem_req, mem_we, i_ack, d_ack and grant_owner = 0; mem_addr, mem_wdata, i_rdata and d_rdata = 0; last-grant = I, so D wins the first tie.
REQ-023 A reset during BUSY SHALL abort the transaction without any ack, and a mem_ready arriving after reset SHALL be ignored.
REQ-024 The first grant SHALL be possible in the first cycle after rstn rises.

Verification
REQ-025 The bench SHALL cover a single read: i_req=1, i_addr=0x3, memory L=2 returning 0xAAAA...A -> mem_req for 2 cycles with mem_addr=0x3, i_ack pulse at cycle 4, and i_rdata=0xAAAA...A.
REQ-026 The bench SHALL cover a tie after reset: i_req and d_req rise in the same cycle -> D is granted first with grant_owner=1, then I; d_ack precedes i_ack, and the acks never overlap.
REQ-027 The bench SHALL cover continuous contention over 6 transactions with both requesters held high -> grant_owner sequence D, I, D, I, D, I.
REQ-028 The bench SHALL cover a write-back: d_req=1, d_we=1, d_addr=0x9, d_wdata=0x1234 -> mem_we=1, mem_addr=0x9, mem_wdata=0x1234, d_ack after mem_ready, and d_rdata unchanged.
REQ-029 The bench SHALL cover reset mid-BUSY: rstn pulsed low while mem_req=1 -> mem_req drops immediately, no ack is issued, and a stray mem_ready afterwards produces no ack.
REQ-030 The bench SHALL cover field instability: i_addr changed from 0x2 to 0x7 during BUSY -> mem_addr remains 0x2 until completion.
